des_wb_multichannel: RTL



---
 rtl/des_wb_multichannel.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/des_wb_multichannel.sv
// Wishbone register front end driving NCH external block-cipher cores.
// Each channel keeps key, input block, mode, captured result and runs a
// start / wait / capture sequence guarded by a watchdog.
module des_wb_multichannel #(
  parameter int          NCH       = 2,
  parameter int          BLK_W     = 64,
  parameter int          KEY_W     = 64,
  parameter int          TIMEOUT   = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_wb_cyc,
  input  logic                   i_wb_stb,
  input  logic                   i_wb_we,
  input  logic [3:0]             i_wb_sel,
  input  logic [31:0]            i_wb_addr,
  input  logic [31:0]            i_wb_data,
  output logic                   o_wb_ack,
  output logic [31:0]            o_wb_data,
  output logic [NCH-1:0]         o_core_start,
  output logic [NCH-1:0]         o_core_decrypt,
  output logic [NCH*KEY_W-1:0]   o_core_key,
  output logic [NCH*BLK_W-1:0]   o_core_din,
  input  logic [NCH-1:0]         i_core_done,
  input  logic [NCH*BLK_W-1:0]   i_core_dout,
  output logic                   o_irq
);

  localparam int KW = KEY_W / 32;
  localparam int BW = BLK_W / 32;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // Bus-side registers
  logic        r_ack;
  logic [31:0] r_rdata;
  logic        r_irq;

  // Per-channel state
  state_t           r_state     [NCH];
  state_t           w_state_nxt [NCH];
  logic [CW-1:0]    r_cnt       [NCH];
  logic [KEY_W-1:0] r_key       [NCH];
  logic [BLK_W-1:0] r_din       [NCH];
  logic [BLK_W-1:0] r_dout      [NCH];
  logic [NCH-1:0]   r_dec;
  logic [NCH-1:0]   r_irqen;
  logic [NCH-1:0]   r_done;
  logic [NCH-1:0]   r_tmo;

  // Decode
  logic        w_acc;
  logic        w_hit;
  logic        w_glob;
  logic        w_wr;
  logic [4:0]  w_ch;
  logic [3:0]  w_word;
  logic [8:0]  w_gword;
  logic [31:0] w_rdata;
  logic [NCH-1:0] w_chsel;
  logic [NCH-1:0] w_ctrl_wr;
  logic [NCH-1:0] w_start;
  logic [NCH-1:0] w_fin_ok;
  logic [NCH-1:0] w_fin_to;
  logic [NCH-1:0] w_clr;
  logic [NCH-1:0] w_irqv;
  logic           w_unused_addr;

  assign w_acc   = i_wb_cyc & i_wb_stb & ~r_ack;
  assign w_hit   = (i_wb_addr[31:12] == BASE_ADDR[31:12]);
  assign w_glob  = i_wb_addr[11];
  assign w_ch    = i_wb_addr[10:6];
  assign w_word  = i_wb_addr[5:2];
  assign w_gword = i_wb_addr[10:2];
  assign w_wr    = w_acc & i_wb_we & w_hit;
  assign w_irqv  = r_done & r_irqen;
  assign w_unused_addr = &{1'b0, i_wb_addr[1:0]};

  assign o_wb_ack       = r_ack;
  assign o_wb_data      = r_rdata;
  assign o_irq          = r_irq;
  assign o_core_decrypt = r_dec;

  // Per-channel write strobes and completion events
  always_comb begin
    w_chsel   = '0;
    w_ctrl_wr = '0;
    w_start   = '0;
    w_fin_ok  = '0;
    w_fin_to  = '0;
    w_clr     = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      w_chsel[c]   = w_wr & ~w_glob & (w_ch == 5'(c));
      w_ctrl_wr[c] = w_chsel[c] & (w_word == 4'd0) & i_wb_sel[0];
      w_start[c]   = w_ctrl_wr[c] & i_wb_data[0] & (r_state[c] == S_IDLE);
      w_fin_ok[c]  = (r_state[c] == S_WAIT) & i_core_done[c];
      // Counter holds WAIT cycles already spent; abort when this edge completes the TIMEOUT-th.
      w_fin_to[c]  = (r_state[c] == S_WAIT) & ~i_core_done[c] & (TIMEOUT > 0) &
                     ((32'(r_cnt[c]) + 32'd1) == 32'(TIMEOUT));
      w_clr[c]     = (w_chsel[c] & (w_word == 4'd1) & i_wb_sel[0] & i_wb_data[0]) |
                     (w_wr & w_glob & (w_gword == 9'd0) & i_wb_sel[0] & i_wb_data[c]);
    end
  end

  // Channel FSM next state
  always_comb begin
    for (int unsigned c = 0; c < NCH; c++) begin
      w_state_nxt[c] = r_state[c];
      case (r_state[c])
        S_IDLE:  if (w_start[c]) w_state_nxt[c] = S_START;
        S_START: w_state_nxt[c] = S_WAIT;
        S_WAIT:  if (w_fin_ok[c] | w_fin_to[c]) w_state_nxt[c] = S_IDLE;
        default: w_state_nxt[c] = S_IDLE;
      endcase
    end
  end

  // Channel FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned c = 0; c < NCH; c++) r_state[c] <= S_IDLE;
    end else begin
      for (int unsigned c = 0; c < NCH; c++) r_state[c] <= w_state_nxt[c];
    end
  end

  // Channel configuration, data, status and watchdog registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dec   <= '0;
      r_irqen <= '0;
      r_done  <= '0;
      r_tmo   <= '0;
      for (int unsigned c = 0; c < NCH; c++) begin
        r_cnt[c]  <= '0;
        r_key[c]  <= '0;
        r_din[c]  <= '0;
        r_dout[c] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (w_ctrl_wr[c]) begin
          r_irqen[c] <= i_wb_data[2];
          if (r_state[c] == S_IDLE) r_dec[c] <= i_wb_data[1];
        end
        if (w_chsel[c] && r_state[c] == S_IDLE) begin
          for (int unsigned k = 0; k < KW; k++) begin
            if (w_word == 4'(4 + k)) begin
              for (int unsigned b = 0; b < 4; b++) begin
                if (i_wb_sel[b]) r_key[c][32*k+8*b +: 8] <= i_wb_data[8*b +: 8];
              end
            end
          end
          for (int unsigned k = 0; k < BW; k++) begin
            if (w_word == 4'(8 + k)) begin
              for (int unsigned b = 0; b < 4; b++) begin
                if (i_wb_sel[b]) r_din[c][32*k+8*b +: 8] <= i_wb_data[8*b +: 8];
              end
            end
          end
        end
        if (r_state[c] == S_START)     r_cnt[c] <= '0;
        else if (r_state[c] == S_WAIT) r_cnt[c] <= r_cnt[c] + CW'(1);
        // Completion outranks a same-edge clear; start and completion cannot coincide.
        if (w_start[c]) begin
          r_done[c] <= 1'b0;
          r_tmo[c]  <= 1'b0;
        end else if (w_fin_ok[c]) begin
          r_done[c] <= 1'b1;
          r_tmo[c]  <= 1'b0;
          r_dout[c] <= i_core_dout[c*BLK_W +: BLK_W];
        end else if (w_fin_to[c]) begin
          r_done[c] <= 1'b1;
          r_tmo[c]  <= 1'b1;
        end else if (w_clr[c]) begin
          r_done[c] <= 1'b0;
          r_tmo[c]  <= 1'b0;
        end
      end
    end
  end

  // Read data multiplexer
  always_comb begin
    w_rdata = '0;
    if (w_hit) begin
      if (w_glob) begin
        if (w_gword == 9'd0)      w_rdata = 32'(w_irqv);
        else if (w_gword == 9'd1) w_rdata = {8'h02, 8'(NCH), 8'(BLK_W / 8), 8'(KEY_W / 8)};
      end else begin
        for (int unsigned c = 0; c < NCH; c++) begin
          if (w_ch == 5'(c)) begin
            if (w_word == 4'd0) w_rdata = {29'd0, r_irqen[c], r_dec[c], (r_state[c] != S_IDLE)};
            if (w_word == 4'd1) w_rdata = {30'd0, r_tmo[c], r_done[c]};
            for (int unsigned k = 0; k < KW; k++) begin
              if (w_word == 4'(4 + k)) w_rdata = r_key[c][32*k +: 32];
            end
            for (int unsigned k = 0; k < BW; k++) begin
              if (w_word == 4'(8 + k))  w_rdata = r_din[c][32*k +: 32];
              if (w_word == 4'(12 + k)) w_rdata = r_dout[c][32*k +: 32];
            end
          end
        end
      end
    end
  end

  // Bus acknowledge, registered read data and interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_ack   <= w_acc;
      r_rdata <= (w_acc && !i_wb_we) ? w_rdata : '0;
      r_irq   <= |w_irqv;
    end
  end

  // Core-facing outputs
  always_comb begin
    o_core_start = '0;
    o_core_key   = '0;
    o_core_din   = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      o_core_start[c]               = (r_state[c] == S_START);
      o_core_key[c*KEY_W +: KEY_W]  = r_key[c];
      o_core_din[c*BLK_W +: BLK_W]  = r_din[c];
    end
  end

endmodule
